// File: rtl/gen_reg_file_pkg.sv
// Shared access-mode and state encodings for gen_reg_file.
// Read-during-write forwarding is enabled by GEN_REG_BYPASS_EN.
package gen_reg_pkg;
  localparam logic [1:0] SEL_FULL = 2'b00;
  localparam logic [1:0] SEL_HIGH = 2'b01;
  localparam logic [1:0] SEL_LOW  = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;
endpackage

// File: rtl/gen_reg_file_if.sv
// Decode-side access bus of the general register file.
// Carries one write port, two read ports, ready and err.
interface gen_reg_file_if #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 10
);
  logic              clr_req;
  logic              wr_en;
  logic [1:0]        wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] data_in;
  logic [1:0]        rd_sel_a;
  logic [1:0]        rd_sel_b;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              ready;
  logic              err;

  modport master (
    output clr_req, wr_en, wr_sel,
    output wr_addr, data_in,
    output rd_sel_a, rd_sel_b,
    output rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b,
    input  ready, err
  );

  modport slave (
    input  clr_req, wr_en, wr_sel,
    input  wr_addr, data_in,
    input  rd_sel_a, rd_sel_b,
    input  rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b,
    output ready, err
  );
endinterface

// File: rtl/gen_reg_rd_port.sv
// Registered read port: range check, half select, optional forward.
// Forwarding of the same-cycle write is built with GEN_REG_BYPASS_EN.
module gen_reg_rd_port
  import gen_reg_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 6,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic [1:0]        sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem [DEPTH],
`ifdef GEN_REG_BYPASS_EN
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_word,
`endif
  output logic              oor,
  output logic [DATA_W-1:0] rd_data
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int H     = DATA_W / 2;

  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] sel_word;

  assign idx = addr[IDX_W-1:0];
  assign oor = !({1'b0, addr} < (ADDR_W+1)'(DEPTH));

  always_comb begin
    word = mem[idx];
`ifdef GEN_REG_BYPASS_EN
    if (wr_fire && wr_addr == addr)
      word = wr_word;
`endif
    sel_word = word;
    unique case (1'b1)
      (sel == SEL_HIGH):
        sel_word = {{H{1'b0}}, word[DATA_W-1:H]};
      (sel == SEL_LOW):
        sel_word = {{H{1'b0}}, word[H-1:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !active || oor)
      rd_data <= '0;
    else
      rd_data <= sel_word;
  end
endmodule

// File: rtl/gen_reg_file.sv
// Parametrised register file with half-word access and clear engine.
// Build option: GEN_REG_BYPASS_EN forwards same-cycle writes to reads.
module gen_reg_file
  import gen_reg_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 6,
  parameter int ADDR_W = 10
) (
  input logic           clk,
  input logic           rst,
  gen_reg_file_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int H     = DATA_W / 2;

  state_t            state;
  logic [IDX_W-1:0]  cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              ready_q;
  logic              err_q;
  logic              active;
  logic              wa_ok;
  logic              wr_fire;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] wr_word;
  logic              oor_a;
  logic              oor_b;

  assign active  = (state == ST_READY);
  assign wa_ok   = {1'b0, bus.wr_addr} < (ADDR_W+1)'(DEPTH);
  assign wr_idx  = bus.wr_addr[IDX_W-1:0];
  assign wr_fire = !rst && active && bus.wr_en && wa_ok
                && (bus.wr_sel != SEL_NONE);
  assign old_word = mem[wr_idx];

  always_comb begin
    wr_word = old_word;
    unique case (1'b1)
      (bus.wr_sel == SEL_FULL):
        wr_word = bus.data_in;
      (bus.wr_sel == SEL_HIGH):
        wr_word = {bus.data_in[H-1:0], old_word[H-1:0]};
      (bus.wr_sel == SEL_LOW):
        wr_word = {old_word[DATA_W-1:H], bus.data_in[H-1:0]};
      default: ;
    endcase
  end

  // Storage has no reset; the clear engine zeroes it entry by entry.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR)
      mem[cnt] <= '0;
    else if (wr_fire)
      mem[wr_idx] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      cnt     <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state)
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == IDX_W'(DEPTH - 1)) begin
            state   <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        ST_READY: begin
          err_q <= (bus.wr_en && !wa_ok) || oor_a || oor_b;
          if (bus.clr_req) begin
            cnt     <= '0;
            state   <= ST_CLEAR;
            ready_q <= 1'b0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.err   = err_q;

  gen_reg_rd_port #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) u_port_a (
    .clk    (clk),
    .rst    (rst),
    .active (active),
    .sel    (bus.rd_sel_a),
    .addr   (bus.rd_addr_a),
    .mem    (mem),
`ifdef GEN_REG_BYPASS_EN
    .wr_fire(wr_fire),
    .wr_addr(bus.wr_addr),
    .wr_word(wr_word),
`endif
    .oor    (oor_a),
    .rd_data(bus.rd_data_a)
  );

  gen_reg_rd_port #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) u_port_b (
    .clk    (clk),
    .rst    (rst),
    .active (active),
    .sel    (bus.rd_sel_b),
    .addr   (bus.rd_addr_b),
    .mem    (mem),
`ifdef GEN_REG_BYPASS_EN
    .wr_fire(wr_fire),
    .wr_addr(bus.wr_addr),
    .wr_word(wr_word),
`endif
    .oor    (oor_b),
    .rd_data(bus.rd_data_b)
  );
endmodule

// File: tb/tb_gen_reg_file.sv
// Scoreboard bench for gen_reg_file against a word-level model.
// Honours GEN_REG_BYPASS_EN for read-during-write expectations.
module tb_gen_reg_file;
  import gen_reg_pkg::*;

  localparam int DW = 20;
  localparam int DP = 6;
  localparam int AW = 10;
  localparam int HM = 32'h3FF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gen_reg_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  gen_reg_file #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          err;
    logic          rdy;
  } exp_t;

  exp_t q[$];
  int   model[DP];
  int   clr_left = DP;
  int   checks = 0;
  int   errors = 0;

  function automatic int rd_val(int w, logic [1:0] s);
    if (s == SEL_HIGH) return (w >> 10) & HM;
    if (s == SEL_LOW)  return w & HM;
    return w;
  endfunction

  function automatic int merge(int old, logic [1:0] s, int d);
    if (s == SEL_FULL) return d & 32'hFFFFF;
    if (s == SEL_HIGH) return ((d & HM) << 10) | (old & HM);
    if (s == SEL_LOW)  return (old & 32'hFFC00) | (d & HM);
    return old;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit cr, input bit we,
                       input logic [1:0] ws, input int wa, input int d,
                       input logic [1:0] sa, input int aa,
                       input logic [1:0] sb, input int ab);
    exp_t e;
    int   post[DP];
    int   src[DP];
    rst           = r;
    bus.clr_req   = cr;
    bus.wr_en     = we;
    bus.wr_sel    = ws;
    bus.wr_addr   = AW'(wa);
    bus.data_in   = DW'(d);
    bus.rd_sel_a  = sa;
    bus.rd_addr_a = AW'(aa);
    bus.rd_sel_b  = sb;
    bus.rd_addr_b = AW'(ab);
    e.a = '0; e.b = '0; e.err = 1'b0; e.rdy = 1'b0;
    if (r) begin
      clr_left = DP;
    end else if (clr_left > 0) begin
      clr_left--;
      if (clr_left == 0) begin
        for (int i = 0; i < DP; i++) model[i] = 0;
        e.rdy = 1'b1;
      end
    end else begin
      post = model;
      if (we && wa < DP && ws != SEL_NONE)
        post[wa] = merge(model[wa], ws, d);
`ifdef GEN_REG_BYPASS_EN
      src = post;
`else
      src = model;
`endif
      if (aa < DP) e.a = DW'(rd_val(src[aa], sa));
      if (ab < DP) e.b = DW'(rd_val(src[ab], sb));
      e.err = (we && wa >= DP) || aa >= DP || ab >= DP;
      model = post;
      if (cr) clr_left = DP;
      e.rdy = !cr;
    end
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int aa, input int ab);
    drive(0, 0, 0, SEL_FULL, 0, 0, SEL_FULL, aa, SEL_FULL, ab);
  endtask

  task automatic wr(input logic [1:0] ws, input int wa, input int d);
    drive(0, 0, 1, ws, wa, d, SEL_FULL, 0, SEL_FULL, 1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd_data_a", 32'(bus.rd_data_a), 32'(e.a));
        chk("rd_data_b", 32'(bus.rd_data_b), 32'(e.b));
        chk("err", 32'(bus.err), 32'(e.err));
        chk("ready", 32'(bus.ready), 32'(e.rdy));
      end
    end
  end

  initial begin
    @(negedge clk);
    drive(1, 0, 0, SEL_FULL, 0, 0, SEL_FULL, 0, SEL_FULL, 0);
    drive(1, 0, 0, SEL_FULL, 0, 0, SEL_FULL, 0, SEL_FULL, 0);
    for (int i = 0; i < DP + 1; i++) idle(0, 1);
    for (int i = 0; i < DP; i += 2) idle(i, i + 1);

    wr(SEL_FULL, 0, 32'hAAAAA);
    idle(0, 2);

    wr(SEL_FULL, 1, 32'hCCCCC);
    wr(SEL_HIGH, 1, 32'h000F0);
    drive(0, 0, 0, SEL_FULL, 0, 0, SEL_FULL, 1, SEL_HIGH, 1);
    drive(0, 0, 0, SEL_FULL, 0, 0, SEL_LOW, 1, SEL_NONE, 1);

    wr(SEL_LOW, 2, 32'hF0F0F);
    idle(0, 2);

    drive(0, 0, 1, SEL_FULL, 3, 32'h12345, SEL_FULL, 3, SEL_HIGH, 3);
    idle(3, 3);

    wr(SEL_FULL, 6, 32'h55555);
    for (int i = 0; i < DP; i += 2) idle(i, i + 1);
    idle(7, 0);
    drive(0, 0, 1, SEL_NONE, 2, 32'h11111, SEL_FULL, 2, SEL_FULL, 0);

    drive(0, 1, 1, SEL_FULL, 4, 32'h9ABCD, SEL_FULL, 4, SEL_FULL, 0);
    drive(0, 0, 1, SEL_FULL, 5, 32'h77777, SEL_FULL, 5, SEL_FULL, 0);
    for (int i = 0; i < DP; i++) idle(4, 5);
    for (int i = 0; i < DP; i += 2) idle(i, i + 1);

    drive(0, 1, 0, SEL_FULL, 0, 0, SEL_FULL, 0, SEL_FULL, 1);
    idle(0, 1);
    idle(0, 1);
    drive(1, 0, 0, SEL_FULL, 0, 0, SEL_FULL, 0, SEL_FULL, 1);
    for (int i = 0; i < DP + 1; i++) idle(0, 1);

    for (int n = 0; n < 500; n++) begin
      int wa, aa, ab;
      wa = ($urandom_range(0, 15) == 0) ? $urandom_range(DP, 1023)
                                         : $urandom_range(0, DP - 1);
      aa = ($urandom_range(0, 15) == 0) ? $urandom_range(DP, 1023)
                                         : $urandom_range(0, DP - 1);
      ab = ($urandom_range(0, 15) == 0) ? $urandom_range(DP, 1023)
                                         : $urandom_range(0, DP - 1);
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
            $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), wa,
            int'($urandom_range(0, 32'hFFFFF)),
            2'($urandom_range(0, 3)), aa,
            2'($urandom_range(0, 3)), ab);
    end

    idle(0, 1);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gen_reg_file.md
# gen_reg_file

Parametrised general-purpose register file: next generation of the six-entry, 20-bit general register block. It keeps full-word / high-half / low-half access, and adds:
- configurable width and depth;
- two registered read ports and one write port;
- out-of-range detection;
- a sequential clear engine that zeroes every entry after reset or on request.

It sits between instruction decode and the ALU datapath.

## Interface
- `DATA_W`, default 20: word width; must be even, ≥ 4.
- `DEPTH`, default 6: number of registers, ≥ 2.
- `ADDR_W`, default 10: address width; must satisfy DEPTH ≤ 2^ADDR_W.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clr_req` in 1: request a full clear; sampled only in READY.
- `wr_en` in 1: write strobe.
- `wr_sel` in 2: write access mode. 00 = full, 01 = high half, 10 = low half, 11 = no write.
- `wr_addr` in ADDR_W: write address.
- `data_in` in DATA_W: write data. Half modes use `data_in[DATA_W/2-1:0]`.
- `rd_sel_a`, `rd_sel_b` in 2 each: read access mode, same encoding as `wr_sel`. 11 reads the full word.
- `rd_addr_a`, `rd_addr_b` in ADDR_W each: read addresses.
- `rd_data_a`, `rd_data_b` out DATA_W each: registered read data.
- `ready` out 1: high when the file accepts reads and writes.
- `err` out 1: one-cycle pulse on an illegal access.

## Operation
- **Reset values.** While `rst` is high: `rd_data_a` = `rd_data_b` = 0, `ready` = 0, `err` = 0, state = CLEAR, clear counter = 0. Storage is not reset directly; the clear engine zeroes it.
- **State machine.** Two states, CLEAR and READY.
  - CLEAR: write 0 to entry[counter] each cycle and increment the counter. After entry DEPTH-1 is written, go to READY and set `ready` = 1.
  - READY: if `clr_req` = 1, reset the counter to 0, go to CLEAR and drop `ready` the next cycle.
- **Writes.** Performed only in READY with `wr_en` = 1 and `wr_addr` < DEPTH.
  - 00: entry ← `data_in`.
  - 01: entry[DATA_W-1:DATA_W/2] ← `data_in[DATA_W/2-1:0]`; the low half is unchanged.
  - 10: entry[DATA_W/2-1:0] ← `data_in[DATA_W/2-1:0]`; the high half is unchanged.
  - 11: no change, no error.
- **Reads.** Each port is independent.
  - Full mode returns the whole word.
  - Half modes return the selected half right-aligned, with the upper DATA_W/2 bits zero.
  - An address ≥ DEPTH reads 0.
  - In CLEAR, read outputs are 0.
- **Errors.** `err` = 1 for exactly the next cycle when any of these occurs in READY; simultaneous errors give a single pulse:
  - `wr_en` with `wr_addr` ≥ DEPTH;
  - any read address ≥ DEPTH.
- **Writes during CLEAR.** A `wr_en` while in CLEAR is dropped silently, with no `err`.
- **Reset mid-clear.** Asserting `rst` mid-clear restarts the clear from entry 0.
- **Same-address reads.** Both ports may read the same address in the same cycle.

## Timing
- **Read latency.** 1 cycle: address and mode are sampled at edge N, and data is valid after edge N.
- **Write latency.** The write is committed at the sampling edge and is visible to a read issued on the following cycle.
- **Clear duration.** DEPTH cycles. `ready` rises on the edge after entry DEPTH-1 is zeroed, i.e. DEPTH cycles after `rst` deasserts.
- **`clr_req` together with `wr_en`.** The write commits first, then CLEAR begins.
- **Read-during-write, same address.** Governed by the Configuration section.

## Configuration
- **Macro `GEN_REG_BYPASS_EN`.**
- **Defined:** a read issued in the same cycle as a write to the same address returns the merged post-write value. A half write merges with the old word before the read's half selection is applied.
- **Undefined:** that read returns the pre-write value, with no forwarding logic.

## Structure
- **Shared package `gen_reg_pkg`:**
  - access-mode constants `SEL_FULL` = 2'b00, `SEL_HIGH` = 2'b01, `SEL_LOW` = 2'b10, `SEL_NONE` = 2'b11;
  - state encoding `ST_CLEAR` / `ST_READY`.
- **Sub-module `gen_reg_rd_port`:** one natural sub-module, instantiated twice. It performs the combinational half-select, range check and optional bypass merge, and holds the output register.
- **Top level:** holds storage, the write merge, the FSM and clear counter, and the `err` register.

## Test plan
All scenarios use DATA_W = 20, DEPTH = 6.
- **Reset and clear:** hold `rst` 2 cycles, release. Required: `ready` = 0 for 6 cycles then 1; reading r0..r5 (full) returns 0x00000.
- **Full word:** write r0 = 0xAAAAA (sel 00), then read port A r0 (sel 00). Required: `rd_data_a` = 0xAAAAA one cycle later.
- **High half:** write r1 = 0xCCCCC (full), then high-half write with `data_in` = 0x000F0. Required: full read 0x3C0CC; high-half read 0x000F0; low-half read 0x000CC.
- **Low half:** after clear, low-half write r2 with `data_in` = 0xF0F0F. Required: full read 0x0030F on port B while port A reads r0 in the same cycle.
- **Bypass:** write r3 = 0x12345 and read r3 on port A in the same cycle. Required: 0x12345 with `GEN_REG_BYPASS_EN`, 0x00000 without.
- **Errors and re-clear:** write to address 6. Required: one-cycle `err`, no entry changed. Then pulse `clr_req` mid-stream. Required: `ready` low for 6 cycles; a write issued during CLEAR is dropped; all entries read 0 afterwards.
